fetch_byte_queue: RTL

- Byte-granular instruction queue on the fetch side of the fetch→decode interface.
- Accepts up to 16-byte chunks from the I-cache fill path and presents a 16-byte window (byte 0 in bits [7:0]) to decode stage 0.
- Retires the variable number of bytes the decoder reports consumed each handshake.
- Tracks the PC of byte 0 and handles flush/redirect.

---
 rtl/fetch_byte_queue_if.sv | 27 ++
 rtl/fetch_byte_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_byte_queue_if.sv
// Fetch-side handshake bundle: I-cache fill chunks in, decode window out.
// The slave modport is the queue; the master modport is the fill path plus decoder.
interface fetch_byte_queue_if #(
  parameter int unsigned IADDRW = 32
);
  logic              c_valid;
  logic              c_ready;
  logic [127:0]      c_data;
  logic [4:0]        c_bytes;
  logic              f_valid;
  logic              f_ready;
  logic [5:0]        f_bytes_read;
  logic [5:0]        f_valid_bytes;
  logic [127:0]      f_instruction;
  logic [IADDRW-1:0] f_pc;
  logic              f_branch_taken;

  modport master (
    output c_valid, c_data, c_bytes, f_ready, f_bytes_read,
    input  c_ready, f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken
  );

  modport slave (
    input  c_valid, c_data, c_bytes, f_ready, f_bytes_read,
    output c_ready, f_valid, f_valid_bytes, f_instruction, f_pc, f_branch_taken
  );
endinterface

// File: rtl/fetch_byte_queue.sv
// Byte-granular fetch queue feeding a 16-byte window to decode, with flush/redirect.
// Optional FBQ_EMPTY_BYPASS_EN: an empty queue presents an incoming chunk in the same cycle.
module fetch_byte_queue #(
  parameter int unsigned IADDRW = 32,
  parameter int unsigned DEPTH  = 32  // 32, 48 or 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [IADDRW-1:0] flush_pc,
  input  logic              flush_branch_taken,
  fetch_byte_queue_if.slave bus
);

  logic [6:0]        count_q, count_d;
  logic [IADDRW-1:0] pc_q, pc_d;
  logic              bt_q, bt_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [7:0]        merged [DEPTH+16];

  logic [4:0]   fill_bytes;
  logic         c_ready;
  logic         fill;
  logic         consume;
  logic [5:0]   win_cnt;
  logic [127:0] win_data;
  logic [5:0]   n;

  // Illegal sizes above 16 are clamped rather than overrunning the array.
  assign fill_bytes = (bus.c_bytes > 5'd16) ? 5'd16 : bus.c_bytes;
  assign c_ready    = (count_q <= 7'(DEPTH - 16));
  assign fill       = bus.c_valid & c_ready;

  always_comb begin
    win_cnt  = (count_q > 7'd16) ? 6'd16 : count_q[5:0];
    win_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(count_q)) win_data[i*8 +: 8] = mem_q[i];
    end
`ifdef FBQ_EMPTY_BYPASS_EN
    if (count_q == 7'd0 && !flush && bus.c_valid) begin
      win_cnt = {1'b0, fill_bytes};
      for (int i = 0; i < 16; i++) begin
        if (i < int'(fill_bytes)) win_data[i*8 +: 8] = bus.c_data[i*8 +: 8];
      end
    end
`endif
  end

  assign bus.c_ready        = c_ready;
  assign bus.f_valid        = (win_cnt != 6'd0);
  assign bus.f_valid_bytes  = win_cnt;
  assign bus.f_instruction  = win_data;
  assign bus.f_pc           = pc_q;
  assign bus.f_branch_taken = bt_q;

  assign consume = bus.f_valid & bus.f_ready;
  assign n       = !consume ? 6'd0 :
                   (bus.f_bytes_read < win_cnt) ? bus.f_bytes_read : win_cnt;

  // Stored bytes followed by the incoming chunk, then shifted down by n in one step,
  // so a simultaneous fill and consume (or a bypassed chunk) needs no special case.
  always_comb begin
    for (int i = 0; i < DEPTH + 16; i++) begin
      merged[i] = 8'h00;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) merged[i] = mem_q[i];
    end
    for (int i = 0; i < DEPTH + 16; i++) begin
      int rel;
      rel = i - int'(count_q);
      if (fill && rel >= 0 && rel < int'(fill_bytes)) merged[i] = bus.c_data[rel*8 +: 8];
    end
  end

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    bt_d    = bt_q;
    mem_d   = mem_q;
    if (flush) begin
      count_d = 7'd0;
      pc_d    = flush_pc;
      bt_d    = flush_branch_taken;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = merged[i + int'(n)];
      end
      count_d = count_q + 7'(fill ? fill_bytes : 5'd0) - 7'(n);
      pc_d    = pc_q + {{(IADDRW-6){1'b0}}, n};
      if (n != 6'd0) bt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 7'd0;
      pc_q    <= '0;
      bt_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      bt_q    <= bt_d;
    end
  end

  // Payload needs no reset: bytes at or beyond count are masked on the window.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
